// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
// Log-shifter levels are spread across STAGES register stages; the tag rides along unchanged.
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES:0]   adv_s;
  logic              in_ready_s;
  logic [1:0]        op_q   [STAGES];
  logic [1:0]        op_d   [STAGES];
  logic [SHW-1:0]    amt_q  [STAGES];
  logic [SHW-1:0]    amt_d  [STAGES];
  logic              sign_q [STAGES];
  logic              sign_d [STAGES];
  logic [WIDTH-1:0]  res_q  [STAGES];
  logic [WIDTH-1:0]  res_d  [STAGES];
  logic [TAGW-1:0]   tag_q  [STAGES];
  logic [TAGW-1:0]   tag_d  [STAGES];
  logic              zero_q, zero_d;
  logic              unused_s;

  // Only the low SHW bits of the amount source matter.
  assign unused_s = ^in_a[WIDTH-1:SHW];

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] data,
                                                   input logic [1:0] op,
                                                   input logic sign, input int sh);
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> sh) : {WIDTH{1'b0}};
    case (op)
      2'b00:   return data << sh;
      2'b01:   return data >> sh;
      2'b11:   return (data >> sh) | fill;
      2'b10:   return (data >> sh) | (data << (WIDTH - sh));
      default: return data;
    endcase
  endfunction

  // Stage k may load when it is empty or its downstream neighbour advances.
  always_comb begin
    logic a;
    a = out_ready;
    adv_s[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      a = !valid_q[k] || a;
      adv_s[k] = a;
    end
    in_ready_s = adv_s[0] && !flush;
  end

  // Per-stage source selection, shift levels owned by the stage, and load/hold.
  always_comb begin
    logic [1:0]       s_op;
    logic [SHW-1:0]   s_amt;
    logic             s_sign;
    logic [WIDTH-1:0] s_res;
    logic [TAGW-1:0]  s_tag;
    logic             s_v;
    int               p;
    valid_d = valid_q;
    op_d    = op_q;
    amt_d   = amt_q;
    sign_d  = sign_q;
    res_d   = res_q;
    tag_d   = tag_q;
    for (int k = 0; k < STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        s_v = in_valid && in_ready_s;
        s_op = in_op;
        s_amt = in_a[SHW-1:0];
        s_sign = in_b[WIDTH-1];
        s_res = in_b;
        s_tag = in_tag;
      end else begin
        s_v = valid_q[p];
        s_op = op_q[p];
        s_amt = amt_q[p];
        s_sign = sign_q[p];
        s_res = res_q[p];
        s_tag = tag_q[p];
      end
      for (int i = 0; i < SHW; i++) begin
        if ((((i * STAGES) / SHW) == k) && s_amt[i]) begin
          s_res = shift_level(s_res, s_op, s_sign, 1 << i);
        end else begin
          s_res = s_res;
        end
      end
      if (flush) begin
        valid_d[k] = 1'b0;
      end else if (adv_s[k]) begin
        valid_d[k] = s_v;
      end else begin
        valid_d[k] = valid_q[k];
      end
      if (adv_s[k]) begin
        op_d[k] = s_op;
        amt_d[k] = s_amt;
        sign_d[k] = s_sign;
        res_d[k] = s_res;
        tag_d[k] = s_tag;
      end else begin
        op_d[k] = op_q[k];
        amt_d[k] = amt_q[k];
        sign_d[k] = sign_q[k];
        res_d[k] = res_q[k];
        tag_d[k] = tag_q[k];
      end
    end
    zero_d = (res_d[STAGES-1] == {WIDTH{1'b0}});
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        op_q[k]   <= 2'b00;
        amt_q[k]  <= '0;
        sign_q[k] <= 1'b0;
        res_q[k]  <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      zero_q  <= zero_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = valid_q[STAGES-1];
  assign out_result = res_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];
  assign out_zero   = zero_q;
  assign busy       = |valid_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed vectors on a 32/2 instance plus
// small random runs on three other configurations against a bitwise model.
module tb_shift_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero;
  logic        busy;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAGW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=none required=response", nm);
  endtask

  // Bitwise reference, written per output bit rather than as a shifter.
  function automatic logic [63:0] ref_shift(input int w, input logic [1:0] op,
                                            input int amt, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) begin
      case (op)
        2'b00:   r[j] = (j >= amt) ? b[j-amt] : 1'b0;
        2'b01:   r[j] = (j + amt < w) ? b[j+amt] : 1'b0;
        2'b11:   r[j] = (j + amt < w) ? b[j+amt] : b[w-1];
        default: r[j] = b[(j+amt)%w];
      endcase
    end
    return r;
  endfunction

  task automatic push(input logic [31:0] r, input logic [4:0] t);
    exp_q.push_back({r, t});
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic [31:0] r);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = t;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push(r, t);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    fail("send accept");
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: every output handshake pops one expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected output");
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", out_result, mon_e.r);
          chk("tag", out_tag, mon_e.t);
          chk("zero", out_zero, mon_e.r == 32'h0);
        end
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : gs
    localparam int W  = (g == 0) ? 8 : ((g == 1) ? 32 : 64);
    localparam int S  = (g == 0) ? 1 : ((g == 1) ? 5 : 3);
    localparam int SH = $clog2(W);
    logic         rst, iv, ir, fl, ov, orr, oz, bz;
    logic [1:0]   op;
    logic [W-1:0] a, b, res;
    logic [4:0]   tg, otg;
    logic [63:0]  r64, er;
    logic         done;
    logic [63:0]  q_r[$];
    logic [4:0]   q_t[$];
    int           q_c[$];

    shift_pipe #(.WIDTH(W), .STAGES(S), .TAGW(5)) dut_sw (
      .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .in_op(op),
      .in_a(a), .in_b(b), .in_tag(tg), .flush(fl), .out_valid(ov),
      .out_ready(orr), .out_result(res), .out_tag(otg), .out_zero(oz), .busy(bz)
    );

    initial begin
      rst = 1'b1; iv = 1'b0; fl = 1'b0; orr = 1'b1; op = 2'b00;
      a = '0; b = '0; tg = 5'd0; done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
        r64 = {$urandom(), $urandom()};
        b = r64[W-1:0];
        r64 = {$urandom(), $urandom()};
        a = r64[W-1:0];
        if (n < 4) a[SH-1:0] = '0;
        else if (n < 8) a[SH-1:0] = '1;
        op = (n < 8) ? 2'(n) : 2'($urandom_range(0, 3));
        iv = (n < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
        tg = 5'(n);
        @(negedge clk);
        if (iv && ir) begin
          q_r.push_back(ref_shift(W, op, int'(a[SH-1:0]), 64'(b)));
          q_t.push_back(tg);
          q_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
      end
      iv = 1'b0;
      repeat (S + 4) @(posedge clk);
      chk($sformatf("sweep%0d drain", W), q_r.size(), 0);
      done = 1'b1;
    end

    initial begin
      forever begin
        @(negedge clk);
        if (!rst && ov) begin
          if (q_r.size() == 0) begin
            fail($sformatf("sweep%0d unexpected", W));
          end else begin
            er = q_r.pop_front();
            chk($sformatf("sweep%0d result", W), 64'(res), er);
            chk($sformatf("sweep%0d tag", W), otg, q_t.pop_front());
            chk($sformatf("sweep%0d zero", W), oz, er == 64'h0);
            chk($sformatf("sweep%0d latency", W), cyc - q_c.pop_front(), S);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = 32'h0; in_b = 32'h0;
    in_tag = 5'd0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_result", out_result, 0);
    chk("rst out_tag", out_tag, 0);
    chk("rst out_zero", out_zero, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: presented in cycle 0, visible in cycle 2.
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd31; in_b = 32'h1; in_tag = 5'd1;
    @(negedge clk);
    chk("lat in_ready", in_ready, 1);
    if (in_ready) push(32'h80000000, 5'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat early out_valid", out_valid, 0);
    @(negedge clk);
    chk("lat out_valid", out_valid, 1);
    @(posedge clk);
    #1;

    send(2'b01, 32'd4, 32'h80000000, 5'd2, 32'h08000000);
    send(2'b11, 32'd4, 32'h80000000, 5'd3, 32'hF8000000);
    send(2'b10, 32'd4, 32'h000000F1, 5'd4, 32'h1000000F);
    for (int k = 0; k < 4; k++) send(2'(k), 32'h00000020, 32'hA5A50F0F, 5'(5 + k), 32'hA5A50F0F);
    send(2'b00, 32'h00000023, 32'h00000003, 5'd9, 32'h00000018);
    send(2'b00, 32'h00000001, 32'h80000000, 5'd10, 32'h00000000);
    drain();

    // Backpressure: two accepted, then stall with stable output.
    out_ready = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      in_valid = 1'b1; in_op = 2'b01; in_a = 32'(t); in_b = 32'hF0000000; in_tag = 5'(t);
      @(negedge clk);
      chk("bp accept", in_ready, 1);
      if (in_ready) push(32'hF0000000 >> t, 5'(t));
      @(posedge clk);
      #1;
    end
    in_a = 32'd3; in_tag = 5'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp in_ready low", in_ready, 0);
      chk("bp hold valid", out_valid, 1);
      chk("bp hold result", out_result, 32'h78000000);
      chk("bp hold tag", out_tag, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp accept full", in_ready, 1);
    if (in_ready) push(32'h1E000000, 5'd3);
    chk("bp stream", out_valid, 1);
    @(posedge clk);
    #1 in_a = 32'd4; in_tag = 5'd4;
    @(negedge clk);
    chk("bp accept 4", in_ready, 1);
    if (in_ready) push(32'h0F000000, 5'd4);
    chk("bp stream", out_valid, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp stream", out_valid, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp empty", out_valid, 0);
    @(posedge clk);
    #1;
    drain();

    // Flush with two in flight; the head is consumed, the other is killed.
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd4; in_b = 32'h1; in_tag = 5'd11;
    @(negedge clk);
    if (in_ready) push(32'h00000010, 5'd11);
    @(posedge clk);
    #1 in_op = 2'b01; in_a = 32'd8; in_b = 32'h100; in_tag = 5'd12;
    @(posedge clk);
    #1 in_op = 2'b10; in_a = 32'd1; in_b = 32'h1; in_tag = 5'd13; flush = 1'b1;
    @(negedge clk);
    chk("flush in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0; in_op = 2'b11; in_a = 32'd31; in_b = 32'h80000000; in_tag = 5'd14;
    @(negedge clk);
    chk("flush out_valid", out_valid, 0);
    chk("flush busy", busy, 0);
    chk("flush next accept", in_ready, 1);
    if (in_ready) push(32'hFFFFFFFF, 5'd14);
    @(posedge clk);
    #1;
    drain();

    // Asynchronous reset between edges while results are in flight.
    send(2'b00, 32'd16, 32'h0000FFFF, 5'd19, 32'hFFFF0000);
    send(2'b01, 32'd1, 32'h00000002, 5'd20, 32'h00000001);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("areset out_valid", out_valid, 0);
    chk("areset out_result", out_result, 0);
    chk("areset out_tag", out_tag, 0);
    chk("areset out_zero", out_zero, 0);
    chk("areset busy", busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1; in_op = 2'b11; in_a = 32'd8; in_b = 32'hFFFF0000; in_tag = 5'd21;
    @(negedge clk);
    chk("post reset accept", in_ready, 1);
    if (in_ready) push(32'hFFFFFF00, 5'd21);
    @(posedge clk);
    #1;
    drain();

    for (int k = 0; k < 2000; k++) begin
      if (gs[0].done && gs[1].done && gs[2].done) break;
      @(posedge clk);
    end
    if (!(gs[0].done && gs[1].done && gs[2].done)) fail("sweep finish");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the ALU shift path. It performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. The log-shifter levels are split across STAGES register stages, with a valid/ready handshake on both sides and a pass-through destination tag. It sits between the EX issue point and the writeback mux, and lets the shift path close timing at higher clock rates than a single-cycle shifter.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64
- STAGES, 2, pipeline register stages; 1..log2(WIDTH)
- TAGW, 5, width of the pass-through tag (destination register index)
- SHW (localparam), log2(WIDTH), width of the shift amount

Ports:
- clk  input  1  clock; all state on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  input operation present
- in_ready  output  1  block accepts the input this cycle
- in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 ROR
- in_a  input  WIDTH  shift-amount source; only in_a[SHW-1:0] is used
- in_b  input  WIDTH  data to shift
- in_tag  input  TAGW  carried unchanged to out_tag
- flush  input  1  synchronous kill of all in-flight operations
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_result  output  WIDTH  shifted value
- out_tag  output  TAGW  tag of the result
- out_zero  output  1  out_result == 0
- busy  output  1  any stage holds a valid entry

## Operation
- Shift amount: amt = in_a[SHW-1:0]. Higher bits of in_a are ignored.
- If amt = 0, the result is in_b for every op.
- Result definitions:
  - SLL: zero fill from the right.
  - SRL: zero fill from the left.
  - SRA: fill with in_b[WIDTH-1]. The sign bit is captured at input and carried through every stage.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Level i (shift by 2^i, i = 0..SHW-1) is applied in stage floor(i*STAGES/SHW).
  - Each stage register holds: valid, op, the remaining amount bits, the sign bit, the partial result and the tag.
  - Output registers are stage STAGES-1. out_zero is registered alongside the result.
- Flow control per stage k:
  - adv[k] = !valid[k] || adv[k+1]. adv[STAGES] = out_ready.
  - Stage k loads from stage k-1 (or from the input when k = 0) when adv[k] is high. valid[k] takes the upstream valid.
  - in_ready = adv[0] && !flush.
  - An input is accepted when in_valid && in_ready.
- Flush: all valid bits clear at the next edge. Input presented in the flush cycle is not accepted. Data registers may keep stale values. out_valid is 0 the cycle after a flush.
- busy = OR of all valid bits.
- Results leave in the order they were accepted. No entry is dropped or duplicated under backpressure.

## Timing
- Reset values: all valid = 0, out_valid = 0, out_result = 0, out_tag = 0, out_zero = 0, busy = 0. in_ready = 1 while reset is low and flush is low.
- Reset asserted mid-operation clears everything immediately, asynchronously. The first accept is possible in the first cycle after deassertion.
- Latency: an input accepted at edge n gives out_valid = 1 after edge n+STAGES-1, i.e. STAGES cycles from presentation, with out_ready held high.
- Throughput: one operation per cycle while out_ready = 1.
- Backpressure:
  - out_ready = 0 with out_valid = 1 holds out_result, out_tag and out_zero stable.
  - Upstream stages keep filling until every stage is valid. in_ready then drops combinationally in the same cycle.
  - Capacity is STAGES entries.
- Simultaneous events:
  - out_ready together with a full pipe: the shift and the new accept happen in the same cycle (in_ready = 1).
  - flush together with out_ready: the current output is still consumed by the consumer, then the pipe is cleared.
- out_valid, out_result, out_tag and out_zero are registered. in_ready is combinational from valid bits, out_ready and flush.

## Test plan
All scenarios use WIDTH=32, STAGES=2 unless noted.
- Basic ops, out_ready=1:
  - SLL b=0x00000001 a=31 -> 0x80000000, out_valid 2 cycles after presentation.
  - SRL b=0x80000000 a=4 -> 0x08000000.
  - SRA same operands -> 0xF8000000.
  - ROR b=0x000000F1 a=4 -> 0x1000000F.
  - a=0 -> b unchanged for all four ops.
- Amount masking and flag: SLL b=0x00000003 a=0x00000023 -> amt 3 -> 0x00000018. SLL b=0x80000000 a=1 -> 0x00000000 with out_zero=1.
- Backpressure: hold out_ready=0 and present 4 back-to-back ops with tags 1..4.
  - Tags 1,2 are accepted, then in_ready=0.
  - Raise out_ready: tags 1,2,3,4 emerge in order, one per cycle, with correct results.
  - Output is stable throughout the stall.
- Flush: with 2 ops in flight, assert flush together with a new in_valid.
  - The next cycle has out_valid=0 and busy=0, and the new op was not accepted (in_ready=0).
  - The op presented the following cycle completes normally.
- Reset: assert reset asynchronously mid-stream, between edges. All outputs are 0 immediately. After deassertion, SRA b=0xFFFF0000 a=8 -> 0xFFFFFF00.
- Parameter sweep: WIDTH=8/STAGES=1, WIDTH=32/STAGES=5, WIDTH=64/STAGES=3.
  - Random ops are checked against the reference model.
  - Latency equals STAGES for every configuration.
